// File: rtl/vga_sync_gen_pkg.sv
// vga_timing_pkg: default 640x480@60 raster timing and the phase type shared by
// the sync generator and anything that wants to decode or debug raster position.
package vga_timing_pkg;

  localparam int unsigned H_VISIBLE = 640;
  localparam int unsigned H_FRONT   = 16;
  localparam int unsigned H_SYNC    = 96;
  localparam int unsigned H_BACK    = 48;
  localparam int unsigned H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;

  localparam int unsigned V_VISIBLE = 480;
  localparam int unsigned V_FRONT   = 10;
  localparam int unsigned V_SYNC    = 2;
  localparam int unsigned V_BACK    = 33;
  localparam int unsigned V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  typedef enum logic [1:0] {
    PH_VISIBLE,
    PH_FRONT,
    PH_SYNC,
    PH_BACK
  } vga_phase_t;

endpackage

// File: rtl/vga_sync_gen_if.sv
// vga_sync_gen_if: raster timing bundle between the sync generator and the
// pixel/colour stage.
//   PixelEn     pixel-clock enable strobe (driven by the consumer side / clock gen)
//   HCount      current pixel column
//   VCount      current line
//   HSync       horizontal sync, active low
//   VSync       vertical sync, active low
//   Video_On    high inside the visible area
//   LineEnd     high on the last column of a line
//   FrameStart  high at column 0 of line 0
// master: the timing generator. slave: the consumer.
interface vga_sync_gen_if #(
  parameter int unsigned CW = 10
);

  logic          PixelEn;
  logic [CW-1:0] HCount;
  logic [CW-1:0] VCount;
  logic          HSync;
  logic          VSync;
  logic          Video_On;
  logic          LineEnd;
  logic          FrameStart;

  modport master (
    input  PixelEn,
    output HCount, VCount, HSync, VSync, Video_On, LineEnd, FrameStart
  );

  modport slave (
    output PixelEn,
    input  HCount, VCount, HSync, VSync, Video_On, LineEnd, FrameStart
  );

endinterface

// File: rtl/vga_sync_gen_axis_counter.sv
// vga_axis_counter: mod-N up counter for one raster axis.
//   clk_i    clock, state updates on posedge
//   clear_i  synchronous active-high clear, wins over en_i
//   en_i     advance by one when high
//   count_o  current count, 0..N-1
//   wrap_o   high while count_o == N-1 (the next enabled edge wraps to 0)
module vga_axis_counter #(
  parameter int unsigned CW = 10,
  parameter int unsigned N  = 800
) (
  input  logic          clk_i,
  input  logic          clear_i,
  input  logic          en_i,
  output logic [CW-1:0] count_o,
  output logic          wrap_o
);

  localparam logic [CW-1:0] Last = CW'(N - 1);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (en_i) begin
      count_d = (count_q == Last) ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (clear_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign wrap_o  = (count_q == Last);

endmodule

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: VGA raster timing generator. Two mod-N axis counters plus a pure
// decode of sync, blanking and line/frame markers from the counts.
//   Clock  system clock, posedge
//   Clear  synchronous active-high reset, priority over PixelEn
//   bus    vga_sync_gen_if.master: PixelEn in; HCount, VCount, HSync, VSync,
//          Video_On, LineEnd, FrameStart out
// Build option VGA_REG_OUT_EN: all outputs registered on PixelEn edges (one tick
// behind the counters, mutually aligned). Undefined: outputs are zero-latency decode.
module vga_sync_gen #(
  parameter int unsigned CW        = 10,
  parameter int unsigned H_VISIBLE = vga_timing_pkg::H_VISIBLE,
  parameter int unsigned H_FRONT   = vga_timing_pkg::H_FRONT,
  parameter int unsigned H_SYNC    = vga_timing_pkg::H_SYNC,
  parameter int unsigned H_BACK    = vga_timing_pkg::H_BACK,
  parameter int unsigned V_VISIBLE = vga_timing_pkg::V_VISIBLE,
  parameter int unsigned V_FRONT   = vga_timing_pkg::V_FRONT,
  parameter int unsigned V_SYNC    = vga_timing_pkg::V_SYNC,
  parameter int unsigned V_BACK    = vga_timing_pkg::V_BACK
) (
  input logic             Clock,
  input logic             Clear,
  vga_sync_gen_if.master  bus
);

  import vga_timing_pkg::*;

  localparam int unsigned HTotal = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned VTotal = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  if ((64'd1 << CW) < 64'(HTotal)) begin : g_bad_h
    $error("vga_sync_gen: CW too narrow for horizontal total");
  end
  if ((64'd1 << CW) < 64'(VTotal)) begin : g_bad_v
    $error("vga_sync_gen: CW too narrow for vertical total");
  end

  // Phase boundaries: first count of each non-visible phase.
  localparam logic [CW-1:0] HFront = CW'(H_VISIBLE);
  localparam logic [CW-1:0] HSyncS = CW'(H_VISIBLE + H_FRONT);
  localparam logic [CW-1:0] HBack  = CW'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [CW-1:0] HLast  = CW'(HTotal - 1);
  localparam logic [CW-1:0] VFront = CW'(V_VISIBLE);
  localparam logic [CW-1:0] VSyncS = CW'(V_VISIBLE + V_FRONT);
  localparam logic [CW-1:0] VBack  = CW'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [CW-1:0] h_count, v_count;
  logic          h_wrap, v_wrap;

  vga_axis_counter #(.CW(CW), .N(HTotal)) u_h_cnt (
    .clk_i   (Clock),
    .clear_i (Clear),
    .en_i    (bus.PixelEn),
    .count_o (h_count),
    .wrap_o  (h_wrap)
  );

  // Vertical advances on the same edge the horizontal counter wraps.
  vga_axis_counter #(.CW(CW), .N(VTotal)) u_v_cnt (
    .clk_i   (Clock),
    .clear_i (Clear),
    .en_i    (bus.PixelEn & h_wrap),
    .count_o (v_count),
    .wrap_o  (v_wrap)
  );

  vga_phase_t h_phase, v_phase;

  always_comb begin
    if (h_count < HFront)      h_phase = PH_VISIBLE;
    else if (h_count < HSyncS) h_phase = PH_FRONT;
    else if (h_count < HBack)  h_phase = PH_SYNC;
    else                       h_phase = PH_BACK;

    if (v_count < VFront)      v_phase = PH_VISIBLE;
    else if (v_count < VSyncS) v_phase = PH_FRONT;
    else if (v_count < VBack)  v_phase = PH_SYNC;
    else                       v_phase = PH_BACK;
  end

  logic hsync_c, vsync_c, video_on_c, line_end_c, frame_start_c;

  always_comb begin
    hsync_c       = (h_phase != PH_SYNC);
    vsync_c       = (v_phase != PH_SYNC);
    video_on_c    = (h_phase == PH_VISIBLE) && (v_phase == PH_VISIBLE);
    line_end_c    = (h_count == HLast);
    frame_start_c = (h_count == '0) && (v_count == '0);
  end

`ifdef VGA_REG_OUT_EN
  logic [CW-1:0] h_count_q, v_count_q;
  logic          hsync_q, vsync_q, video_on_q, line_end_q, frame_start_q;

  // Reset values equal the decode of (0,0), so both builds start identically.
  always_ff @(posedge Clock) begin
    if (Clear) begin
      h_count_q     <= '0;
      v_count_q     <= '0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      video_on_q    <= 1'b1;
      line_end_q    <= 1'b0;
      frame_start_q <= 1'b1;
    end else if (bus.PixelEn) begin
      h_count_q     <= h_count;
      v_count_q     <= v_count;
      hsync_q       <= hsync_c;
      vsync_q       <= vsync_c;
      video_on_q    <= video_on_c;
      line_end_q    <= line_end_c;
      frame_start_q <= frame_start_c;
    end
  end

  assign bus.HCount     = h_count_q;
  assign bus.VCount     = v_count_q;
  assign bus.HSync      = hsync_q;
  assign bus.VSync      = vsync_q;
  assign bus.Video_On   = video_on_q;
  assign bus.LineEnd    = line_end_q;
  assign bus.FrameStart = frame_start_q;
`else
  assign bus.HCount     = h_count;
  assign bus.VCount     = v_count;
  assign bus.HSync      = hsync_c;
  assign bus.VSync      = vsync_c;
  assign bus.Video_On   = video_on_c;
  assign bus.LineEnd    = line_end_c;
  assign bus.FrameStart = frame_start_c;
`endif

  // Vertical wrap marker is implied by FrameStart; kept for debug probing only.
  logic unused_v_wrap;
  assign unused_v_wrap = v_wrap;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: a default 640x480 instance and a tiny-timing instance
// (so whole frames fit in a short run), both checked every clock against a model
// that tracks the linear raster position and derives expected outputs arithmetically.
module tb_vga_sync_gen;

  typedef struct {
    int hv, hf, hs, hb, vv, vf, vs, vb;
  } tim_t;

  typedef struct {
    logic [9:0] h;
    logic [9:0] v;
    logic       hs, vs, von, le, fs;
  } exp_t;

  logic clk;
  logic clr;

  int checks = 0;
  int errors = 0;

  vga_sync_gen_if #(.CW(10)) bus_a ();
  vga_sync_gen_if #(.CW(10)) bus_b ();

  vga_sync_gen #(.CW(10)) dut_a (
    .Clock (clk),
    .Clear (clr),
    .bus   (bus_a)
  );

  vga_sync_gen #(
    .CW(10), .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_VISIBLE(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(2)
  ) dut_b (
    .Clock (clk),
    .Clear (clr),
    .bus   (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  tim_t ta, tb;
  int   pos_a, pos_b;
  exp_t reg_a, reg_b;

  function automatic exp_t decode(int p, tim_t t);
    exp_t e;
    int htot, h, v;
    htot  = t.hv + t.hf + t.hs + t.hb;
    h     = p % htot;
    v     = p / htot;
    e.h   = 10'(h);
    e.v   = 10'(v);
    e.hs  = !((h >= t.hv + t.hf) && (h < t.hv + t.hf + t.hs));
    e.vs  = !((v >= t.vv + t.vf) && (v < t.vv + t.vf + t.vs));
    e.von = (h < t.hv) && (v < t.vv);
    e.le  = (h == htot - 1);
    e.fs  = (p == 0);
    return e;
  endfunction

  function automatic int frame_len(tim_t t);
    return (t.hv + t.hf + t.hs + t.hb) * (t.vv + t.vf + t.vs + t.vb);
  endfunction

  function automatic exp_t expect_a();
`ifdef VGA_REG_OUT_EN
    return reg_a;
`else
    return decode(pos_a, ta);
`endif
  endfunction

  function automatic exp_t expect_b();
`ifdef VGA_REG_OUT_EN
    return reg_b;
`else
    return decode(pos_b, tb);
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    exp_t ea, eb;
    ea = expect_a();
    eb = expect_b();
    chk("A.HCount",     32'(bus_a.HCount),     32'(ea.h));
    chk("A.VCount",     32'(bus_a.VCount),     32'(ea.v));
    chk("A.HSync",      32'(bus_a.HSync),      32'(ea.hs));
    chk("A.VSync",      32'(bus_a.VSync),      32'(ea.vs));
    chk("A.Video_On",   32'(bus_a.Video_On),   32'(ea.von));
    chk("A.LineEnd",    32'(bus_a.LineEnd),    32'(ea.le));
    chk("A.FrameStart", 32'(bus_a.FrameStart), 32'(ea.fs));
    chk("B.HCount",     32'(bus_b.HCount),     32'(eb.h));
    chk("B.VCount",     32'(bus_b.VCount),     32'(eb.v));
    chk("B.HSync",      32'(bus_b.HSync),      32'(eb.hs));
    chk("B.VSync",      32'(bus_b.VSync),      32'(eb.vs));
    chk("B.Video_On",   32'(bus_b.Video_On),   32'(eb.von));
    chk("B.LineEnd",    32'(bus_b.LineEnd),    32'(eb.le));
    chk("B.FrameStart", 32'(bus_b.FrameStart), 32'(eb.fs));
  endtask

  // One clock: drive at negedge, update model at posedge, sample 1 ns later.
  task automatic cycle(input bit c, input bit en);
    @(negedge clk);
    clr           = c;
    bus_a.PixelEn = en;
    bus_b.PixelEn = en;
    @(posedge clk);
    if (c) begin
      pos_a = 0;
      pos_b = 0;
      reg_a = decode(0, ta);
      reg_b = decode(0, tb);
    end else if (en) begin
      reg_a = decode(pos_a, ta);
      reg_b = decode(pos_b, tb);
      pos_a = (pos_a + 1) % frame_len(ta);
      pos_b = (pos_b + 1) % frame_len(tb);
    end
    #1;
    check_all();
  endtask

  int hs_low_a, vs_low_b, fs_b;

  initial begin
    ta = '{640, 16, 96, 48, 480, 10, 2, 33};
    tb = '{8, 2, 3, 3, 6, 2, 2, 2};
    pos_a = 0;
    pos_b = 0;
    reg_a = decode(0, ta);
    reg_b = decode(0, tb);
    clr           = 1'b1;
    bus_a.PixelEn = 1'b1;
    bus_b.PixelEn = 1'b1;

    // Clear held with PixelEn high; reset values are fixed constants.
    repeat (3) cycle(1'b1, 1'b1);
    chk("rst.HCount",     32'(bus_a.HCount),     32'd0);
    chk("rst.VCount",     32'(bus_a.VCount),     32'd0);
    chk("rst.HSync",      32'(bus_a.HSync),      32'd1);
    chk("rst.VSync",      32'(bus_a.VSync),      32'd1);
    chk("rst.Video_On",   32'(bus_a.Video_On),   32'd1);
    chk("rst.LineEnd",    32'(bus_a.LineEnd),    32'd0);
    chk("rst.FrameStart", 32'(bus_a.FrameStart), 32'd1);

    // One full line at full rate.
    hs_low_a = 0;
    for (int i = 0; i < 800; i++) begin
      cycle(1'b0, 1'b1);
      if (bus_a.HSync === 1'b0) hs_low_a++;
    end
    chk("A.hsync_width", 32'(hs_low_a), 32'd96);
`ifndef VGA_REG_OUT_EN
    chk("A.line1.HCount", 32'(bus_a.HCount), 32'd0);
    chk("A.line1.VCount", 32'(bus_a.VCount), 32'd1);
`endif

    // Two whole frames of the small instance: 192 ticks per frame.
    vs_low_b = 0;
    fs_b     = 0;
    for (int i = 0; i < 384; i++) begin
      cycle(1'b0, 1'b1);
      if (bus_b.VSync === 1'b0) vs_low_b++;
      if (bus_b.FrameStart === 1'b1) fs_b++;
    end
    chk("B.vsync_ticks", 32'(vs_low_b), 32'd64);
    chk("B.framestarts", 32'(fs_b), 32'd2);

    // Half-rate enable: counts move only on enabled edges.
    for (int i = 0; i < 3200; i++) cycle(1'b0, 1'((i % 2) == 0));

    // Random enable with occasional Clear.
    for (int i = 0; i < 3000; i++) cycle(($urandom % 150) == 0, 1'($urandom % 2));

    // Clear mid-sync at HCount=700, VCount=1 together with PixelEn.
    cycle(1'b1, 1'b0);
    for (int i = 0; i < 1500; i++) cycle(1'b0, 1'b1);
`ifndef VGA_REG_OUT_EN
    chk("pre.HCount", 32'(bus_a.HCount), 32'd700);
    chk("pre.HSync",  32'(bus_a.HSync),  32'd0);
`endif
    cycle(1'b1, 1'b1);
    chk("clr.HCount", 32'(bus_a.HCount), 32'd0);
    chk("clr.VCount", 32'(bus_a.VCount), 32'd0);
    chk("clr.HSync",  32'(bus_a.HSync),  32'd1);
    for (int i = 0; i < 20; i++) cycle(1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
